// File: rtl/p_fxp_acc_pipe.sv
// Pipelined streaming fixed-point accumulator: registered saturating adder tree per beat,
// then a saturating accumulator across beats up to in_last. Optional macro FXP_ACC_CNT_EN adds out_cnt.

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP '{sign: 1'b1, prec: 8'd8}
`endif
`ifndef Disable
`define Disable 1'b0
`endif

package p_fxp_acc_pipe_pkg;
   typedef struct packed {
      logic       sign;
      logic [7:0] prec;
   } dconf_t;
endpackage

module p_fxp_acc_pipe
   import p_fxp_acc_pipe_pkg::*;
#(
   parameter int      LANE  = 8,
   parameter dconf_t  CONF  = `DEF_DCONF_FXP,
   localparam int     PREC  = int'(CONF.prec),
   localparam int     STAGE = (LANE > 1) ? $clog2(LANE) : 0
)(
   input  logic                       clk,
   input  logic                       reset_,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [LANE-1:0][PREC-1:0]  in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PREC-1:0]            out,
   output logic                       ovf,
   output logic                       udf,
   output logic                       rounded
`ifdef FXP_ACC_CNT_EN
   ,
   output logic [15:0]                out_cnt
`endif
);

   localparam int NPAD = 1 << STAGE;

   // Returns {clamped, result}; result is clamped to the signed or unsigned range of CONF.
   function automatic logic [PREC:0] sat_add(input logic [PREC-1:0] a, input logic [PREC-1:0] b);
      logic [PREC:0] s;
      logic [PREC:0] r;
      if (CONF.sign) begin
         s = {a[PREC-1], a} + {b[PREC-1], b};
         if (s[PREC] != s[PREC-1])
            r = {1'b1, s[PREC], {(PREC-1){~s[PREC]}}};
         else
            r = {1'b0, s[PREC-1:0]};
      end else begin
         s = {1'b0, a} + {1'b0, b};
         if (s[PREC])
            r = {1'b1, {PREC{1'b1}}};
         else
            r = {1'b0, s[PREC-1:0]};
      end
      return r;
   endfunction

   logic adv;
   logic out_valid_reg;
   assign adv      = !out_valid_reg || out_ready;
   assign in_ready = adv;

   // Valid/last tags, one entry per tree level; level 0 is the input itself.
   genvar gi;
   generate
      for (gi = 0; gi <= STAGE; gi++) begin : g_lvl
         logic vld;
         logic lst;
         if (gi == 0) begin : g_in
            assign vld = in_valid;
            assign lst = in_last;
         end else begin : g_reg
            always_ff @(posedge clk or negedge reset_) begin
               if (!reset_) begin
                  vld <= 1'b0;
                  lst <= 1'b0;
               end else if (adv) begin
                  vld <= g_lvl[gi-1].vld;
                  lst <= g_lvl[gi-1].lst;
               end
            end
         end
      end
   endgenerate

   // Heap-ordered tree: node n has children 2n and 2n+1; leaves NPAD..2*NPAD-1 are the lanes.
   generate
      for (gi = 1; gi < 2*NPAD; gi++) begin : g_node
         logic [PREC-1:0] node_data;
         logic            node_ovf;
         if (gi >= NPAD) begin : g_leaf
            if (gi - NPAD < LANE) begin : g_lane
               assign node_data = in[gi-NPAD];
            end else begin : g_pad
               assign node_data = '0;
            end
            assign node_ovf = 1'b0;
         end else begin : g_add
            logic [PREC:0] sum_next;
            assign sum_next = sat_add(g_node[2*gi].node_data, g_node[2*gi+1].node_data);
            always_ff @(posedge clk or negedge reset_) begin
               if (!reset_) begin
                  node_data <= '0;
                  node_ovf  <= 1'b0;
               end else if (adv) begin
                  node_data <= sum_next[PREC-1:0];
                  node_ovf  <= sum_next[PREC] | g_node[2*gi].node_ovf | g_node[2*gi+1].node_ovf;
               end
            end
         end
      end
   endgenerate

   logic [PREC-1:0] tree_out;
   logic            tree_ovf;
   logic            t_valid;
   logic            t_last;
   assign tree_out = g_node[1].node_data;
   assign tree_ovf = g_node[1].node_ovf;
   assign t_valid  = g_lvl[STAGE].vld;
   assign t_last   = g_lvl[STAGE].lst;

   logic [PREC-1:0] acc_reg;
   logic [PREC-1:0] out_reg;
   logic            first_reg;
   logic            sticky_reg;
   logic            ovf_reg;
   logic [PREC:0]   acc_next;
   logic            beat_ovf;

   assign acc_next = sat_add(first_reg ? '0 : acc_reg, tree_out);
   assign beat_ovf = acc_next[PREC] | tree_ovf;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         acc_reg       <= '0;
         out_reg       <= '0;
         first_reg     <= 1'b1;
         sticky_reg    <= 1'b0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (adv) begin
         // adv with a pending result implies it is being accepted this cycle.
         out_valid_reg <= 1'b0;
         if (t_valid) begin
            if (t_last) begin
               out_reg       <= acc_next[PREC-1:0];
               ovf_reg       <= sticky_reg | beat_ovf;
               out_valid_reg <= 1'b1;
               acc_reg       <= '0;
               first_reg     <= 1'b1;
               sticky_reg    <= 1'b0;
            end else begin
               acc_reg    <= acc_next[PREC-1:0];
               first_reg  <= 1'b0;
               sticky_reg <= sticky_reg | beat_ovf;
            end
         end
      end
   end

`ifdef FXP_ACC_CNT_EN
   logic [15:0] cnt_reg;
   logic [15:0] out_cnt_reg;
   logic [15:0] cnt_next;
   assign cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt_reg     <= '0;
         out_cnt_reg <= '0;
      end else if (adv && t_valid) begin
         if (t_last) begin
            out_cnt_reg <= cnt_next;
            cnt_reg     <= '0;
         end else begin
            cnt_reg <= cnt_next;
         end
      end
   end
   assign out_cnt = out_cnt_reg;
`endif

   assign out_valid = out_valid_reg;
   assign out       = out_reg;
   assign ovf       = ovf_reg;
   assign udf       = `Disable;
   assign rounded   = `Disable;

endmodule

// File: tb/tb_p_fxp_acc_pipe.sv
// Scoreboard bench for p_fxp_acc_pipe: signed LANE=4 instance plus an unsigned LANE=3 instance
// exercising zero-padded lanes.

module tb_p_fxp_acc_pipe;
   import p_fxp_acc_pipe_pkg::*;

   localparam dconf_t CONF_S = '{sign: 1'b1, prec: 8'd8};
   localparam dconf_t CONF_U = '{sign: 1'b0, prec: 8'd8};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_;
   logic            in_valid, in_ready, in_last, out_valid, out_ready, ovf, udf, rounded;
   logic [3:0][7:0] in_data;
   logic [7:0]      out_data;
   logic            u_in_valid, u_in_ready, u_in_last, u_out_valid, u_out_ready, u_ovf, u_udf, u_rounded;
   logic [2:0][7:0] u_in_data;
   logic [7:0]      u_out_data;
`ifdef FXP_ACC_CNT_EN
   logic [15:0]     out_cnt, u_out_cnt;
`endif

   p_fxp_acc_pipe #(.LANE(4), .CONF(CONF_S)) dut (
      .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in(in_data), .out_valid(out_valid), .out_ready(out_ready), .out(out_data), .ovf(ovf),
      .udf(udf), .rounded(rounded)
`ifdef FXP_ACC_CNT_EN
      , .out_cnt(out_cnt)
`endif
   );

   p_fxp_acc_pipe #(.LANE(3), .CONF(CONF_U)) dut_u (
      .clk(clk), .reset_(reset_), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_last(u_in_last),
      .in(u_in_data), .out_valid(u_out_valid), .out_ready(u_out_ready), .out(u_out_data), .ovf(u_ovf),
      .udf(u_udf), .rounded(u_rounded)
`ifdef FXP_ACC_CNT_EN
      , .out_cnt(u_out_cnt)
`endif
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int accept_cyc = 0;
   bit rand_done = 0;

   typedef struct { int val; int ovf; int cnt; } exp_t;
   exp_t sb[$];

   // Reference model state for the signed instance.
   int m_acc = 0;
   int m_ovf = 0;
   int m_cnt = 0;

   task automatic check(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_s(input int v, inout int c);
      if (v > 127) begin c = 1; return 127; end
      if (v < -128) begin c = 1; return -128; end
      return v;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic send_beat(input int l0, input int l1, input int l2, input int l3, input bit last);
      int n, c, s01, s23, s;
      in_data[0] = l0[7:0];
      in_data[1] = l1[7:0];
      in_data[2] = l2[7:0];
      in_data[3] = l3[7:0];
      in_valid = 1'b1;
      in_last  = last;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      accept_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      c   = 0;
      s01 = sat_s(l0 + l1, c);
      s23 = sat_s(l2 + l3, c);
      s   = sat_s(s01 + s23, c);
      m_acc = sat_s(m_acc + s, c);
      m_ovf = m_ovf | c;
      m_cnt++;
      if (last) begin
         sb.push_back('{val: m_acc, ovf: m_ovf, cnt: m_cnt});
         $display("beat {%0d,%0d,%0d,%0d} last -> expect out=%0d ovf=%0d cnt=%0d", l0, l1, l2, l3, m_acc, m_ovf, m_cnt);
         m_acc = 0;
         m_ovf = 0;
         m_cnt = 0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb.size(), 0);
   endtask

   task automatic u_send(input int a, input int b, input int c, input int exp_val, input int exp_ovf);
      int n;
      u_in_data[0] = a[7:0];
      u_in_data[1] = b[7:0];
      u_in_data[2] = c[7:0];
      u_in_valid = 1'b1;
      u_in_last  = 1'b1;
      @(posedge clk);
      #1;
      u_in_valid = 1'b0;
      u_in_last  = 1'b0;
      n = 0;
      @(negedge clk);
      while (!u_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("u_out_valid", u_out_valid, 1);
      check("u_out", int'(u_out_data), exp_val);
      check("u_ovf", u_ovf, exp_ovf);
`ifdef FXP_ACC_CNT_EN
      check("u_out_cnt", int'(u_out_cnt), 1);
`endif
      $display("unsigned {%0d,%0d,%0d} -> out=%0d ovf=%0d", a, b, c, u_out_data, u_ovf);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on each accepted result and checks stall stability.
   initial begin
      exp_t e;
      logic [7:0] held_out;
      logic held_ovf;
      bit stalled;
      stalled = 0;
      held_out = '0;
      held_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_) begin
            stalled = 0;
         end else if (out_valid) begin
            if (stalled) begin
               check("hold_out", int'(out_data), int'(held_out));
               check("hold_ovf", ovf, held_ovf);
            end
            if (out_ready) begin
               if (sb.size() == 0) begin
                  check("spurious_result", out_valid, 0);
               end else begin
                  e = sb.pop_front();
                  check("out", int'($signed(out_data)), e.val);
                  check("ovf", ovf, e.ovf);
`ifdef FXP_ACC_CNT_EN
                  check("out_cnt", int'(out_cnt), e.cnt);
`endif
                  $display("result out=%0d ovf=%0d (expected %0d/%0d)", $signed(out_data), ovf, e.val, e.ovf);
               end
               stalled = 0;
            end else begin
               check("in_ready_stall", in_ready, 0);
               held_out = out_data;
               held_ovf = ovf;
               stalled  = 1;
            end
         end else begin
            stalled = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nb, l[4];
      reset_ = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      u_in_valid = 1'b0; u_in_last = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_ = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", int'(out_data), 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      check("udf_tied", udf, 0);
      check("rounded_tied", rounded, 0);
      @(posedge clk);
      #1;

      // Single beat, latency STAGE+1 = 3.
      send_beat(1, 2, 3, 4, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", cyc - accept_cyc, 3);
      drain();
      @(posedge clk); #1;

      // Multi-beat vector, then clamp cases and sticky clearing; back-to-back.
      send_beat(10, 10, 10, 10, 0);
      send_beat(10, 10, 10, 10, 0);
      send_beat(10, 10, 10, 10, 1);
      send_beat(100, 100, 0, 0, 1);
      send_beat(1, 1, 1, 1, 1);
      send_beat(-100, -100, -100, -100, 1);
      send_beat(100, 20, 0, 0, 0);
      send_beat(-30, 0, 0, 0, 0);
      send_beat(50, 0, 0, 0, 1);
      drain();
      @(posedge clk); #1;

      // Continuous single-beat vectors with a 5-cycle downstream stall.
      fork
         begin
            for (int i = 0; i < 20; i++) send_beat(i, -i, 2*i, 3, 1);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      @(posedge clk); #1;

      // Randomised vectors with random backpressure.
      rand_done = 0;
      fork
         begin
            for (int v = 0; v < 30; v++) begin
               nb = int'($urandom_range(1, 4));
               for (int b = 0; b < nb; b++) begin
                  for (int k = 0; k < 4; k++)
                     l[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                                        : int'($urandom_range(0, 16)) - 8;
                  send_beat(l[0], l[1], l[2], l[3], b == nb - 1);
               end
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      @(posedge clk); #1;

      // Reset mid-vector discards the partial sum.
      send_beat(10, 10, 10, 10, 0);
      send_beat(10, 10, 10, 10, 0);
      reset_ = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      m_acc = 0; m_ovf = 0; m_cnt = 0;
      @(posedge clk);
      #1;
      reset_ = 1'b1;
      send_beat(5, 5, 5, 5, 1);
      drain();
      @(posedge clk); #1;

      // Unsigned instance with one zero-padded lane.
      u_send(200, 100, 0, 255, 1);
      u_send(10, 20, 30, 60, 0);
      u_send(255, 0, 1, 255, 1);
      u_send(100, 50, 100, 250, 0);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/p_fxp_acc_pipe.md
Name: p_fxp_acc_pipe

Overview:
Pipelined, streaming fixed-point accumulator with saturation. Each beat carries LANE operands, which are reduced by a registered binary adder tree. Per-beat sums are then accumulated across a multi-beat vector delimited by in_last. Sits between operand fetch and activation in the perceptron datapath, and replaces the combinational single-shot accumulator for long dot products.

Parameters:
LANE, 8, operands per input beat; any value >= 1, non-power-of-two is zero-padded to 1<<$clog2(LANE)
CONF, `DEF_DCONF_FXP, dconf_t format shared by inputs, tree and output
PREC, CONF.prec, word width (derived, not overridden)
STAGE, $clog2(LANE), number of registered tree levels (derived; 0 when LANE=1)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_last  in  1  final beat of the current vector
in  in  LANE*PREC  packed [LANE-1:0][PREC-1:0] operands
out_valid  out  1  vector result valid
out_ready  in  1  downstream accept
out  out  PREC  saturated vector sum
ovf  out  1  saturation occurred anywhere in this vector; qualified by out_valid
udf  out  1  tied `Disable (interface parity)
rounded  out  1  tied `Disable (interface parity)

Behaviour:
- Reset (reset_=0, async): all pipeline valids=0, acc=0, first=1, out_valid=0, out=0, ovf=0, in_ready=1 on the first cycle after release.
- Global advance: adv = !out_valid || out_ready. Every pipeline register (tree levels, acc, output) updates only when adv=1. in_ready = adv. No bubble squeezing.
- Tree: level k registers the pairwise sums of level k-1. Each valid/last tag travels with its data. Padded lanes are 0.
- Saturating add (tree and acc): signed (CONF.sign=1) clamps to [-2^(PREC-1), 2^(PREC-1)-1]; unsigned clamps to [0, 2^PREC-1]. Any clamp sets the vector's sticky ovf.
- Accumulator stage, on a valid beat with adv=1:
  - sum = sat((first ? 0 : acc) + tree_out).
  - If tag last=0: acc<=sum, first<=0.
  - If tag last=1: out<=sum, ovf<=sticky|clamp, out_valid<=1, acc<=0, first<=1, sticky<=0.
- Latency: the last beat accepted at cycle t gives out_valid=1 at t+STAGE+1. Throughput is 1 beat/cycle while out_ready=1 or no result is pending.
- Output handshake: out/ovf hold stable while out_valid && !out_ready. out_valid clears on accept unless a new result lands in the same cycle, in which case it stays 1 with new data.
- A single-beat vector (in_last on the first beat) is legal. Back-to-back vectors need no idle cycle.
- in_valid=0 cycles propagate as bubbles and do not disturb acc.
- Saturation is applied per add, not at the end, so the result is order-dependent once clamping occurs. This is intended and matches the tree order lane0+lane1, lane2+lane3, ...
- Async reset mid-vector discards the partial accumulation and all in-flight beats.

Optional Feature:
FXP_ACC_CNT_EN:
- Defined: adds output port out_cnt [15:0], the number of beats in the reported vector, qualified by out_valid. The beat counter saturates at 16'hFFFF, resets to 0, and restarts on each new vector.
- Undefined: no port and no counter logic.

Test Plan:
1. LANE=4, PREC=8 signed. One beat {1,2,3,4}, last=1 -> out_valid at +3 cycles, out=10, ovf=0.
2. Three beats of {10,10,10,10}, last on the third -> out=120, ovf=0. With FXP_ACC_CNT_EN, out_cnt=3.
3. {100,100,0,0}, last -> out=127, ovf=1. Next vector {1,1,1,1}, last -> out=4, ovf=0 (sticky cleared).
4. {-100,-100,-100,-100}, last -> out=-128, ovf=1. Unsigned CONF with {200,100,0,0} -> out=255, ovf=1.
5. Continuous 1-beat vectors, out_ready=0 for 5 cycles -> in_ready=0 within those cycles, out held stable, no beat lost or duplicated. Every subsequent result is correct after release.
6. reset_ pulsed low after 2 beats of a 4-beat vector -> out_valid=0 immediately. The following vector {5,5,5,5}, last -> out=20, with no residue from the prior partial sum.
